// File: rtl/ddr2_burst_ctrl.sv
// ddr2_burst_ctrl: moves bursts between the FrontPanel pipe FIFOs and MCB port 0,
// arbitrating write and read bursts round-robin over wrapping byte addresses.
module ddr2_burst_ctrl #(
  parameter int unsigned BURST_LEN = 32,
  parameter logic [31:0] ADDR_MAX  = 32'h03FF_FFFF,
  parameter int unsigned OB_DEPTH  = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             c3_clk0,
  input  logic             c3_rst0,
  input  logic             calib_done,
  input  logic             write_mode,
  input  logic             read_mode,
  input  logic             addr_rst,
  input  logic [CNT_W-1:0] ib_count,
  output logic             ib_rd_en,
  input  logic [31:0]      ib_dout,
  input  logic [CNT_W-1:0] ob_count,
  output logic             ob_wr_en,
  output logic [31:0]      ob_din,
  output logic             p0_cmd_en,
  output logic [2:0]       p0_cmd_instr,
  output logic [5:0]       p0_cmd_bl,
  output logic [29:0]      p0_cmd_byte_addr,
  input  logic             p0_cmd_full,
  output logic             p0_wr_en,
  output logic [31:0]      p0_wr_data,
  output logic [3:0]       p0_wr_mask,
  input  logic             p0_wr_empty,
  output logic             p0_rd_en,
  input  logic [31:0]      p0_rd_data,
  input  logic             p0_rd_empty,
  input  logic             p0_wr_underrun,
  input  logic             p0_rd_overflow,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA} state_t;

  localparam logic [31:0] STEP = 32'(4 * BURST_LEN);
  localparam logic [6:0]  BL_C = 7'(BURST_LEN);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [29:0] wr_addr_q, wr_addr_d;
  logic [29:0] rd_addr_q, rd_addr_d;
  logic        last_rd_q, last_rd_d;
  logic        rst_pend_q, rst_pend_d;
  logic        p0_wr_en_q;
  logic        ob_wr_en_q;
  logic [31:0] ob_din_q;
  logic        error_q;
  logic        wr_ok, rd_ok;

  // Wide sum keeps the wrap comparison free of overflow.
  function automatic logic [29:0] addr_next(input logic [29:0] a);
    logic [31:0] s;
    s = {2'b00, a} + STEP;
    return (s > ADDR_MAX) ? '0 : s[29:0];
  endfunction

  assign wr_ok = calib_done && write_mode && (32'(ib_count) >= BURST_LEN) && p0_wr_empty;
  assign rd_ok = calib_done && read_mode && (32'(ob_count) <= (OB_DEPTH - BURST_LEN));

  // Next-state, address bookkeeping and strobes.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    wr_addr_d        = wr_addr_q;
    rd_addr_d        = rd_addr_q;
    last_rd_d        = last_rd_q;
    rst_pend_d       = rst_pend_q;
    ib_rd_en         = 1'b0;
    p0_rd_en         = 1'b0;
    p0_cmd_en        = 1'b0;
    p0_cmd_instr     = 3'b000;
    p0_cmd_byte_addr = '0;

    if (addr_rst && (state_q != IDLE)) rst_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (addr_rst || rst_pend_q) begin
          wr_addr_d  = '0;
          rd_addr_d  = '0;
          rst_pend_d = 1'b0;
        end else if (wr_ok && (!rd_ok || last_rd_q)) begin
          state_d = WR_DATA;
        end else if (rd_ok) begin
          state_d = RD_CMD;
        end
      end
      WR_DATA: begin
        ib_rd_en = (cnt_q < BL_C);
        if (cnt_q == BL_C) state_d = WR_CMD;
        else               cnt_d   = cnt_q + 7'd1;
      end
      WR_CMD: begin
        p0_cmd_byte_addr = wr_addr_q;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          wr_addr_d = addr_next(wr_addr_q);
          last_rd_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_CMD: begin
        p0_cmd_instr     = 3'b001;
        p0_cmd_byte_addr = rd_addr_q;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          rd_addr_d = addr_next(rd_addr_q);
          last_rd_d = 1'b1;
          cnt_d     = '0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (cnt_q == BL_C) begin
          state_d = IDLE;
        end else if (!p0_rd_empty) begin
          p0_rd_en = 1'b1;
          cnt_d    = cnt_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, addresses, data-path pipeline and sticky error.
  always_ff @(posedge c3_clk0) begin
    if (c3_rst0) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      last_rd_q  <= 1'b1;
      rst_pend_q <= 1'b0;
      p0_wr_en_q <= 1'b0;
      ob_wr_en_q <= 1'b0;
      ob_din_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      last_rd_q  <= last_rd_d;
      rst_pend_q <= rst_pend_d;
      p0_wr_en_q <= ib_rd_en;
      ob_wr_en_q <= p0_rd_en;
      ob_din_q   <= p0_rd_data;
      error_q    <= error_q | p0_wr_underrun | p0_rd_overflow;
    end
  end

  assign p0_wr_en   = p0_wr_en_q;
  assign p0_wr_data = ib_dout;
  assign p0_wr_mask = '0;
  assign p0_cmd_bl  = 6'(BURST_LEN - 1);
  assign ob_wr_en   = ob_wr_en_q;
  assign ob_din     = ob_din_q;
  assign busy       = (state_q != IDLE);
  assign error      = error_q;

endmodule

// File: tb/tb_ddr2_burst_ctrl.sv
// Directed bench for ddr2_burst_ctrl (BURST_LEN=32, ADDR_MAX=0xFF so addresses wrap).
module tb_ddr2_burst_ctrl;

  localparam int unsigned BL = 32;

  logic        c3_clk0 = 1'b0;
  logic        c3_rst0, calib_done, write_mode, read_mode, addr_rst;
  logic [10:0] ib_count, ob_count;
  logic        ib_rd_en, ob_wr_en, p0_cmd_en, p0_cmd_full, p0_wr_en, p0_wr_empty;
  logic [31:0] ib_dout = '0;
  logic [31:0] ob_din, p0_wr_data, p0_rd_data;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic [3:0]  p0_wr_mask;
  logic        p0_rd_en, p0_rd_empty, p0_wr_underrun, p0_rd_overflow, busy, error;

  int n_checks = 0;
  int n_errors = 0;
  int ib_idx = 0;
  int rd_idx = 0;
  logic rnd_empty = 1'b0;

  logic [2:0]  cmd_instr_q[$];
  logic [29:0] cmd_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] ob_data_q[$];
  int n_ib = 0, n_rd = 0, n_busy = 0, viol_full = 0, viol_consec = 0;
  logic prev_cmd = 1'b0;

  always #5 c3_clk0 = ~c3_clk0;

  ddr2_burst_ctrl #(
    .BURST_LEN(BL),
    .ADDR_MAX (32'h0000_00FF),
    .OB_DEPTH (1024),
    .CNT_W    (11)
  ) dut (
    .c3_clk0(c3_clk0), .c3_rst0(c3_rst0), .calib_done(calib_done),
    .write_mode(write_mode), .read_mode(read_mode), .addr_rst(addr_rst),
    .ib_count(ib_count), .ib_rd_en(ib_rd_en), .ib_dout(ib_dout),
    .ob_count(ob_count), .ob_wr_en(ob_wr_en), .ob_din(ob_din),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
    .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
    .p0_wr_empty(p0_wr_empty), .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
    .p0_rd_empty(p0_rd_empty), .p0_wr_underrun(p0_wr_underrun),
    .p0_rd_overflow(p0_rd_overflow), .busy(busy), .error(error)
  );

  // Pipe-in FIFO model: data one cycle after pop.
  always @(posedge c3_clk0) begin
    if (ib_rd_en) begin
      ib_dout <= 32'hA500_0000 + 32'(ib_idx);
      ib_idx  <= ib_idx + 1;
    end
  end

  // MCB read FIFO model, first-word-fall-through.
  always @(posedge c3_clk0) begin
    if (p0_rd_en) rd_idx <= rd_idx + 1;
  end
  assign p0_rd_data = 32'hB000_0000 + 32'(rd_idx);

  initial begin
    p0_rd_empty = 1'b0;
    forever begin
      @(posedge c3_clk0);
      #1;
      p0_rd_empty = rnd_empty && ($urandom_range(0, 1) == 1);
    end
  end

  // Observe outputs mid-cycle.
  always @(negedge c3_clk0) begin
    if (p0_cmd_en) begin
      cmd_instr_q.push_back(p0_cmd_instr);
      cmd_addr_q.push_back(p0_cmd_byte_addr);
      if (p0_cmd_full) viol_full++;
      if (prev_cmd) viol_consec++;
    end
    prev_cmd = p0_cmd_en;
    if (ib_rd_en) n_ib++;
    if (p0_wr_en) wr_data_q.push_back(p0_wr_data);
    if (p0_rd_en) n_rd++;
    if (ob_wr_en) ob_data_q.push_back(ob_din);
    if (busy) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c3_clk0);
      #1;
    end
  endtask

  task automatic wait_cmds(input int target, input int budget, output int lat);
    lat = 0;
    while ((cmd_addr_q.size() < target) && (lat < budget)) begin
      tick(1);
      lat++;
    end
    check("cmd_wait", 32'(cmd_addr_q.size()), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && (n < budget)) begin
      tick(1);
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int busy_snap;
    c3_rst0 = 1'b1; calib_done = 1'b0; write_mode = 1'b1; read_mode = 1'b0;
    addr_rst = 1'b0; ib_count = 11'd64; ob_count = 11'd0; p0_cmd_full = 1'b0;
    p0_wr_empty = 1'b1; p0_wr_underrun = 1'b0; p0_rd_overflow = 1'b0;
    tick(3);

    check("rst_busy",     32'(busy), 32'd0);
    check("rst_ib_rd_en", 32'(ib_rd_en), 32'd0);
    check("rst_wr_en",    32'(p0_wr_en), 32'd0);
    check("rst_cmd_en",   32'(p0_cmd_en), 32'd0);
    check("rst_rd_en",    32'(p0_rd_en), 32'd0);
    check("rst_ob_wr_en", 32'(ob_wr_en), 32'd0);
    check("rst_ob_din",   ob_din, 32'd0);
    check("rst_error",    32'(error), 32'd0);
    check("rst_bl",       32'(p0_cmd_bl), 32'd31);
    check("rst_mask",     32'(p0_wr_mask), 32'd0);
    check("rst_addr",     32'(p0_cmd_byte_addr), 32'd0);

    c3_rst0 = 1'b0;
    tick(100);
    check("nocal_ib_rd", 32'(n_ib), 32'd0);
    check("nocal_cmds",  32'(cmd_addr_q.size()), 32'd0);
    check("nocal_busy",  32'(n_busy), 32'd0);

    // First write burst: grant to command is BL+2 cycles after the grant cycle.
    calib_done = 1'b1; ib_count = 11'd32;
    wait_cmds(1, 200, lat);
    write_mode = 1'b0;
    check("wr1_latency", 32'(lat), 32'(BL + 3));
    check("wr1_instr",   32'(cmd_instr_q[0]), 32'd0);
    check("wr1_addr",    32'(cmd_addr_q[0]), 32'h00);
    check("wr1_ib_pops", 32'(n_ib), 32'd32);
    check("wr1_words",   32'(wr_data_q.size()), 32'd32);
    tick(1);
    check("wr1_idle",    32'(busy), 32'd0);

    write_mode = 1'b1;
    wait_cmds(2, 200, lat);
    write_mode = 1'b0;
    check("wr2_addr",  32'(cmd_addr_q[1]), 32'h80);
    check("wr2_words", 32'(wr_data_q.size()), 32'd64);

    write_mode = 1'b1;
    wait_cmds(3, 200, lat);
    write_mode = 1'b0;
    check("wr3_wrap_addr", 32'(cmd_addr_q[2]), 32'h00);
    tick(2);

    // Not enough pipe-in data, then read blocked by pipe-out headroom.
    busy_snap = n_busy;
    ib_count = 11'd31; write_mode = 1'b1;
    tick(50);
    write_mode = 1'b0;
    check("ib31_cmds", 32'(cmd_addr_q.size()), 32'd3);
    check("ib31_busy", 32'(n_busy - busy_snap), 32'd0);
    read_mode = 1'b1; ob_count = 11'd993;
    tick(50);
    check("ob993_cmds", 32'(cmd_addr_q.size()), 32'd3);
    check("ob993_busy", 32'(n_busy - busy_snap), 32'd0);

    ob_count = 11'd992; rnd_empty = 1'b1;
    wait_cmds(4, 50, lat);
    read_mode = 1'b0;
    check("rd1_latency", 32'(lat), 32'd2);
    check("rd1_instr",   32'(cmd_instr_q[3]), 32'd1);
    check("rd1_addr",    32'(cmd_addr_q[3]), 32'h00);
    wait_idle(1000);
    check("rd1_pops",    32'(n_rd), 32'd32);
    check("rd1_words",   32'(ob_data_q.size()), 32'd32);

    // Both sides eligible: W,R,W,R.
    ib_count = 11'd32; ob_count = 11'd0; write_mode = 1'b1; read_mode = 1'b1;
    wait_cmds(8, 3000, lat);
    write_mode = 1'b0; read_mode = 1'b0;
    wait_idle(1000);
    check("arb0_instr", 32'(cmd_instr_q[4]), 32'd0);
    check("arb1_instr", 32'(cmd_instr_q[5]), 32'd1);
    check("arb2_instr", 32'(cmd_instr_q[6]), 32'd0);
    check("arb3_instr", 32'(cmd_instr_q[7]), 32'd1);
    check("arb0_addr",  32'(cmd_addr_q[4]), 32'h80);
    check("arb1_addr",  32'(cmd_addr_q[5]), 32'h80);
    check("arb2_addr",  32'(cmd_addr_q[6]), 32'h00);
    check("arb3_addr",  32'(cmd_addr_q[7]), 32'h00);

    // Command FIFO full for 10 WR_CMD cycles; write_mode drops meanwhile.
    p0_cmd_full = 1'b1; write_mode = 1'b1;
    tick(44);
    check("full_no_cmd", 32'(cmd_addr_q.size()), 32'd8);
    check("full_busy",   32'(busy), 32'd1);
    write_mode = 1'b0; p0_cmd_full = 1'b0;
    tick(20);
    check("full_one_cmd", 32'(cmd_addr_q.size()), 32'd9);
    check("full_instr",   32'(cmd_instr_q[8]), 32'd0);
    check("full_addr",    32'(cmd_addr_q[8]), 32'h80);
    check("full_idle",    32'(busy), 32'd0);

    write_mode = 1'b1;
    wait_cmds(10, 200, lat);
    write_mode = 1'b0;
    check("pre_rst_addr", 32'(cmd_addr_q[9]), 32'h00);
    tick(2);

    // addr_rst mid-burst: current command keeps old address, next uses 0.
    write_mode = 1'b1;
    tick(5);
    addr_rst = 1'b1;
    tick(1);
    addr_rst = 1'b0;
    wait_cmds(11, 200, lat);
    write_mode = 1'b0;
    check("arst_old_addr", 32'(cmd_addr_q[10]), 32'h80);
    tick(2);
    write_mode = 1'b1;
    wait_cmds(12, 200, lat);
    write_mode = 1'b0;
    check("arst_wr_addr", 32'(cmd_addr_q[11]), 32'h00);
    tick(2);
    read_mode = 1'b1;
    wait_cmds(13, 200, lat);
    read_mode = 1'b0;
    check("arst_rd_instr", 32'(cmd_instr_q[12]), 32'd1);
    check("arst_rd_addr",  32'(cmd_addr_q[12]), 32'h00);
    wait_idle(1000);

    // Data integrity across all bursts.
    check("wr_total", 32'(wr_data_q.size()), 32'(9 * BL));
    for (int i = 0; i < wr_data_q.size(); i++)
      check("wr_word", wr_data_q[i], 32'hA500_0000 + 32'(i));
    check("ob_total", 32'(ob_data_q.size()), 32'(4 * BL));
    for (int i = 0; i < ob_data_q.size(); i++)
      check("ob_word", ob_data_q[i], 32'hB000_0000 + 32'(i));
    check("cmd_while_full", 32'(viol_full), 32'd0);
    check("cmd_back2back",  32'(viol_consec), 32'd0);

    // Sticky error.
    p0_rd_overflow = 1'b1;
    tick(1);
    p0_rd_overflow = 1'b0;
    check("err_set", 32'(error), 32'd1);
    tick(5);
    check("err_sticky", 32'(error), 32'd1);
    c3_rst0 = 1'b1;
    tick(2);
    c3_rst0 = 1'b0;
    check("err_cleared", 32'(error), 32'd0);
    p0_wr_underrun = 1'b1;
    tick(1);
    p0_wr_underrun = 1'b0;
    check("err_underrun", 32'(error), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
